seq_divider: RTL
================

Name: seq_divider

Overview:
- Sequential restoring (shift-subtract) integer divider; the inverse of the team's shift-add multiplier.
- Computes quotient and remainder of an N-bit dividend by an N-bit divisor, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath.
- Uses a start/busy/done handshake so a controlling FSM can launch an operation and collect the result.

Parameters:
N, 4, operand width in bits (N >= 2); quotient and remainder are also N bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  request to begin a division; sampled only in IDLE
A  input  N  dividend; captured on the edge that accepts start
B  input  N  divisor; captured on the edge that accepts start
busy  output  1  high while an accepted operation is iterating
done  output  1  one-cycle pulse, results valid
quotient  output  N  registered quotient; held until next completion
remainder  output  N  registered remainder; held until next completion
div_by_zero  output  1  registered flag for last operation; held with results

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal working registers and iteration counter are cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN.
- IDLE, start=1 at edge k, B!=0:
  - Capture A into the working quotient register and zero into the (N+1)-bit partial remainder.
  - Counter=N, busy=1, state->RUN.
- IDLE, start=1 at edge k, B=0:
  - Stay in IDLE, no iterations.
  - At edge k: quotient=all ones, remainder=A, div_by_zero=1, done=1 for one cycle; busy stays 0.
- RUN, each edge performs one iteration:
  - Shift {partial remainder, working quotient} left by 1.
  - Trial-subtract B from the partial remainder, using N+1 bits so the borrow is explicit.
  - Non-negative result: keep it and set quotient LSB=1.
  - Negative result: restore the previous value and set quotient LSB=0.
  - Decrement the counter.
- Completion, at edge k+N (last iteration):
  - quotient and remainder output registers load the final values; div_by_zero=0.
  - done=1 for the following cycle only; busy=0; state->IDLE.
- Latency: N edges from accept to results; throughput one operation per N+1 cycles (start may be re-asserted in the cycle done is high).
- start while busy is ignored: no restart, operands not recaptured.
- A and B may change freely after the accepting edge.
- Outputs never change except at reset or a completion edge.
- Invariant on normal completion (unsigned): A == quotient*B + remainder, remainder < B.
- Dividend < divisor: quotient=0, remainder=A.

Optional Feature:
- Macro SEQ_DIVIDER_SIGNED_EN.
- Defined: A and B are two's complement.
  - At accept, magnitudes are captured and the result signs are recorded: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - The unsigned core runs unchanged.
  - On the completion edge, outputs are negated per the recorded signs, giving truncation toward zero.
  - Latency is unchanged.
  - Overflow case A = most negative, B = -1: quotient = most negative (wraps), remainder = 0, div_by_zero=0.
  - B=0: quotient = all ones (-1), remainder = A, div_by_zero=1.
- Not defined: operands are unsigned; no sign logic is synthesized.

Test Plan:
1. N=4, reset, then A=13, B=3, start one cycle -> busy high 4 cycles; done pulse with quotient=4, remainder=1, div_by_zero=0.
2. A=15, B=1 -> quotient=15, remainder=0 after 4 edges. Then A=2, B=9 -> quotient=0, remainder=2.
3. A=7, B=0 -> done on the cycle after the accepting edge, busy never high; quotient=15, remainder=7, div_by_zero=1. Next op A=9, B=2 clears the flag (quotient=4, remainder=1).
4. A=12, B=5 accepted; at cycle 2 drive start=1 with A=1, B=1 -> ignored; result quotient=2, remainder=2. Start re-asserted during the done cycle is accepted.
5. A=14, B=3 accepted; pull rst low at cycle 2 -> all outputs 0 immediately (asynchronous); no done pulse after release; next op computes correctly.
6. With SEQ_DIVIDER_SIGNED_EN:
   - A=-7 (1001), B=2 -> quotient=-3 (1101), remainder=-1 (1111).
   - A=-8, B=-1 -> quotient=1000, remainder=0.
   - A=6, B=-4 -> quotient=-1, remainder=2.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider -- sequential restoring (shift-subtract) integer divider.
//
// Produces one quotient bit per clock. After an operation is accepted,
// the quotient and remainder arrive N edges later. A start/busy/done
// handshake lets a controlling FSM launch an operation and collect the result.
//
// Optional feature (compile-time macro SEQ_DIVIDER_SIGNED_EN):
//   When defined, A and B are two's complement and the result truncates
//   toward zero. When undefined, the operands are unsigned and no sign
//   logic is built.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   start        request a division (sampled only while idle)
//   A, B         dividend / divisor, captured on the accepting edge
//   busy         high while an accepted operation iterates
//   done         one-cycle pulse; results valid
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  registered divide-by-zero flag of the last operation
module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic           zero_div;
  logic           last_iter;

  // A restored partial remainder is always below the divisor, so it fits
  // in N bits; the extra (N+1)th bit only exists in the shifted value.
  logic [N-1:0]   prem;
  logic [N-1:0]   wq;
  logic [N-1:0]   divisor;
  logic [CNT_W-1:0] count;

  logic [N:0]     shifted;
  logic [N:0]     trial;
  logic [N-1:0]   prem_nxt;
  logic [N-1:0]   wq_nxt;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [N-1:0]   q_fin;
  logic [N-1:0]   r_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic           q_neg;
  logic           r_neg;

  // Two's-complement negation. The most negative value maps to itself,
  // and its magnitude is still correct when read as unsigned.
  function automatic logic [N-1:0] negate_if(input logic [N-1:0] v,
                                             input logic         neg);
    return neg ? (~v + N'(1)) : v;
  endfunction
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    zero_div  = 1'b0;
    last_iter = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (B != '0) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end else begin
            zero_div  = 1'b1;
          end
        end
      end
      RUN: begin
        if (count == CNT_W'(1)) begin
          last_iter = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring iteration: shift, trial-subtract, keep or restore
  always_comb begin
    shifted = {prem, wq[N-1]};
    trial   = shifted - {1'b0, divisor};
    if (trial[N]) begin
      // Borrow out: the divisor did not fit, so restore
      prem_nxt = shifted[N-1:0];
      wq_nxt   = {wq[N-2:0], 1'b0};
    end else begin
      prem_nxt = trial[N-1:0];
      wq_nxt   = {wq[N-2:0], 1'b1};
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    a_mag = negate_if(A, A[N-1]);
    b_mag = negate_if(B, B[N-1]);
    q_fin = negate_if(wq_nxt, q_neg);
    r_fin = negate_if(prem_nxt, r_neg);
`else
    a_mag = A;
    b_mag = B;
    q_fin = wq_nxt;
    r_fin = prem_nxt;
`endif
  end

  // Working registers and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prem        <= '0;
      wq          <= '0;
      divisor     <= '0;
      count       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (accept) begin
        prem    <= '0;
        wq      <= a_mag;
        divisor <= b_mag;
        count   <= CNT_W'(N);
`ifdef SEQ_DIVIDER_SIGNED_EN
        q_neg   <= A[N-1] ^ B[N-1];
        r_neg   <= A[N-1];
`endif
      end else if (state == RUN) begin
        prem  <= prem_nxt;
        wq    <= wq_nxt;
        count <= count - CNT_W'(1);
      end

      if (zero_div) begin
        // Division by zero resolves immediately, with no iterations
        quotient    <= '1;
        remainder   <= A;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end else if (last_iter) begin
        quotient    <= q_fin;
        remainder   <= r_fin;
        div_by_zero <= 1'b0;
        done        <= 1'b1;
      end
    end
  end

  assign busy = (state == RUN);

endmodule
